matrix_read_master: RTL
=======================

// Module: matrix_read_master
// PURPOSE
//  AXI4-Lite read-channel master that fetches matrix A, then matrix B (M_ROW x M_COL, 32-bit, row-major) from memory.
//  Sits upstream of the weight and input memories: drives axi_rready, read_array_a/read_array_b and read_index_b, which qualify M_AXI_RVALID/M_AXI_RDATA for them.
//  One read outstanding at a time; pulses read_done when both matrices are delivered, used to launch the systolic array.
// PARAMETERS
//  M_ROW       9             rows per matrix
//  M_COL       9             cols per matrix; M_ROW*M_COL <= 255 (8-bit index)
//  A_BASE_ADDR 32'h4000_0000 byte address of A[0][0]
//  B_BASE_ADDR 32'h4000_0400 byte address of B[0][0]
// PORTS
//  M_AXI_ACLK      in   1   clock; all logic on rising edge
//  M_AXI_ARESET    in   1   async reset, active-high
//  init_txn_pulse  in   1   1-cycle start request
//  M_AXI_ARADDR    out  32  read address
//  M_AXI_ARPROT    out  3   tied 3'b000
//  M_AXI_ARVALID   out  1   address valid
//  M_AXI_ARREADY   in   1   address accepted
//  M_AXI_RDATA     in   32  read data (passes to memories, unused here)
//  M_AXI_RRESP     in   2   read response
//  M_AXI_RVALID    in   1   data valid
//  axi_rready      out  1   data ready
//  read_array_a    out  1   current beat belongs to matrix A
//  read_array_b    out  1   current beat belongs to matrix B
//  read_index_b    out  8   row-major element index of current beat (shared by A and B)
//  busy            out  1   fetch in progress
//  read_done       out  1   1-cycle pulse, both matrices fetched
//  read_error      out  1   sticky: any RRESP[1]==1 since last start
// BEHAVIOUR
//  Reset (async, M_AXI_ARESET=1), all outputs 0:
//   - state=IDLE; index=0; read_error=0
//  N = M_ROW*M_COL.
//  FSM:
//   - IDLE: init_txn_pulse -> ADDR, index=0, phase=A, read_error cleared.
//   - ADDR: ARVALID=1, ARADDR=base(phase)+4*index, held stable until M_AXI_ARREADY; on ARREADY -> DATA.
//   - DATA: ARVALID=0, axi_rready=1. On M_AXI_RVALID:
//     - phase A, index<N-1 -> index+1 -> ADDR
//     - phase A, index==N-1 -> index=0, phase=B -> ADDR
//     - phase B, index<N-1 -> index+1 -> ADDR
//     - phase B, index==N-1 -> DONE
//   - DONE: read_done=1 for exactly this cycle -> IDLE.
//  Output decode:
//   - read_array_a/read_array_b: registered phase flags, valid in ADDR and DATA; both 0 in IDLE/DONE.
//   - read_index_b: stable through the RVALID&&axi_rready beat that delivers that element.
//   - busy = (state != IDLE).
//  Throughput: 2 cycles/element with zero-wait slave.
//   - init_txn_pulse sampled at edge 0; ARVALID high from cycle 1.
//   - read_done high in cycle 4N+1 (N=9 -> cycle 37).
//  Boundaries and protocol:
//   - init_txn_pulse while busy is ignored; an outstanding AXI read is never aborted.
//   - RRESP[1]==1 (SLVERR/DECERR): read_error set and held until next accepted start; beat still counted and delivered.
//   - ARREADY may arrive in same cycle ARVALID rises.
//   - RVALID while not in DATA is ignored (no data beat expected).
//   - Async reset mid-fetch returns to IDLE immediately with all outputs 0.
// TESTING
//  Tests run with M_ROW=M_COL=3, N=9, zero-wait slave unless stated.
//  1. Reset, then one init_txn_pulse ->
//     - ARADDR sequence 0x4000_0000..0x4000_0020 step 4 with read_array_a=1
//     - then 0x4000_0400..0x4000_0420 with read_array_b=1
//     - read_index_b 0..8 per phase; read_done pulse in cycle 37
//  2. Slave inserts 3-cycle ARREADY delay and 2-cycle RVALID delay on every beat ->
//     - ARADDR/ARVALID stable while stalled; read_done in cycle 1+18*7=127
//     - exactly 18 RVALID&&axi_rready beats
//  3. init_txn_pulse re-asserted at cycle 10 during fetch -> no restart; sequence identical to test 1.
//  4. RRESP=2'b10 on B element 4 ->
//     - read_error=1 from that beat, still 1 after read_done
//     - cleared on next init_txn_pulse
//  5. M_AXI_ARESET asserted during DATA of A element 5 ->
//     - same cycle: ARVALID, axi_rready, busy, read_array_a = 0
//     - new start begins again at 0x4000_0000
//  6. Back-to-back: init_txn_pulse in cycle after read_done -> second full 18-beat sequence, correct addresses.

Source files
------------

// File: rtl/matrix_read_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_read_master                                            |
// | Function : AXI4-Lite read master that fetches matrix A and then matrix B |
// |            (M_ROW x M_COL, 32-bit words, row-major) one read at a time,  |
// |            and qualifies the returned beats for the downstream memories. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module matrix_read_master #(
   parameter int          M_ROW       = 9,
   parameter int          M_COL       = 9,
   parameter logic [31:0] A_BASE_ADDR = 32'h4000_0000,
   parameter logic [31:0] B_BASE_ADDR = 32'h4000_0400
) (
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESET,
   input  logic        init_txn_pulse,
   output logic [31:0] M_AXI_ARADDR,
   output logic [2:0]  M_AXI_ARPROT,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        axi_rready,
   output logic        read_array_a,
   output logic        read_array_b,
   output logic [7:0]  read_index_b,
   output logic        busy,
   output logic        read_done,
   output logic        read_error
);

   // Index of the last element of a matrix; the index register is 8 bits wide.
   localparam logic [7:0] LAST_INDEX = 8'(M_ROW * M_COL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] index;
   logic       phase_b;   // 0 while fetching A, 1 while fetching B

   // Read data and the low response bit are consumed by the memories, not here.
   logic unused_inputs;
   assign unused_inputs = ^{M_AXI_RDATA, M_AXI_RRESP[0]};

   // Byte address of element idx of the matrix selected by ph.
   function automatic logic [31:0] elem_addr(input logic ph, input logic [7:0] idx);
      return (ph ? B_BASE_ADDR : A_BASE_ADDR) + {22'd0, idx, 2'b00};
   endfunction

   assign M_AXI_ARPROT = 3'b000;
   assign read_index_b = index;
   assign busy         = (state != IDLE);

   // Fetch sequencer: one address phase then one data phase per element, A then B.
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state         <= IDLE;
         index         <= 8'd0;
         phase_b       <= 1'b0;
         M_AXI_ARADDR  <= 32'd0;
         M_AXI_ARVALID <= 1'b0;
         axi_rready    <= 1'b0;
         read_array_a  <= 1'b0;
         read_array_b  <= 1'b0;
         read_done     <= 1'b0;
         read_error    <= 1'b0;
      end else begin
         read_done <= 1'b0;
         case (state)
            IDLE: begin
               if (init_txn_pulse) begin
                  state         <= ADDR;
                  index         <= 8'd0;
                  phase_b       <= 1'b0;
                  read_error    <= 1'b0;
                  M_AXI_ARADDR  <= A_BASE_ADDR;
                  M_AXI_ARVALID <= 1'b1;
                  read_array_a  <= 1'b1;
                  read_array_b  <= 1'b0;
               end
            end
            ADDR: begin
               // Address and valid stay put until the slave accepts them.
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  axi_rready    <= 1'b1;
                  state         <= DATA;
               end
            end
            DATA: begin
               if (M_AXI_RVALID) begin
                  axi_rready <= 1'b0;
                  // Error responses are flagged but the beat is still delivered.
                  if (M_AXI_RRESP[1]) begin
                     read_error <= 1'b1;
                  end
                  if (index == LAST_INDEX) begin
                     index <= 8'd0;
                     if (phase_b) begin
                        state        <= DONE;
                        read_done    <= 1'b1;
                        read_array_a <= 1'b0;
                        read_array_b <= 1'b0;
                     end else begin
                        phase_b       <= 1'b1;
                        read_array_a  <= 1'b0;
                        read_array_b  <= 1'b1;
                        M_AXI_ARADDR  <= B_BASE_ADDR;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= ADDR;
                     end
                  end else begin
                     index         <= index + 8'd1;
                     M_AXI_ARADDR  <= elem_addr(phase_b, index + 8'd1);
                     M_AXI_ARVALID <= 1'b1;
                     state         <= ADDR;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
